// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard / redirect controller.
package pipe_hazard_ctrl_pkg;

   typedef enum logic [1:0] {
      PC_JUMP = 2'd0,
      PC_TRAP = 2'd1,
      PC_MEPC = 2'd2
   } pc_sel_t;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      DRAIN = 1'b1
   } ctrl_state_e;

   typedef struct packed {
      logic       irq;
      logic [3:0] code;
   } mcause_t;

   // Default machine interrupt cause codes (software, timer, external).
   localparam logic [3:0] IRQ_CODE_MSI = 4'd3;
   localparam logic [3:0] IRQ_CODE_MTI = 4'd7;
   localparam logic [3:0] IRQ_CODE_MEI = 4'd11;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Bundle of all hazard-controller signals between the datapath and the controller.
// master: datapath side (drives causes, consumes controls); slave: the controller.
interface pipe_hazard_ctrl_if #(
   parameter int NUM_STAGES = 4,
   parameter int NUM_IRQ    = 3,
   parameter int XLEN       = 32,
   parameter int CNT_W      = 32
);
   logic [NUM_STAGES-1:0] stall_cause_i;
   logic [NUM_STAGES-1:0] flush_cause_i;
   logic [NUM_STAGES-1:0] instr_valid_i;
   logic [NUM_IRQ-1:0]    irq_pending_i;
   logic                  irq_global_en_i;
   logic                  trap_valid_i;
   logic                  trap_is_mret_i;
   logic [3:0]            trap_code_i;
   logic [XLEN-1:0]       trap_pc_i;
   logic [XLEN-1:0]       fetch_pc_i;
   logic                  branch_taken_i;

   logic [NUM_STAGES-1:0] stall_o;
   logic [NUM_STAGES-1:0] flush_o;
   logic                  new_pc_en_o;
   logic [1:0]            pc_sel_o;
   logic                  is_trap_o;
   logic                  mret_o;
   logic                  mcause_irq_o;
   logic [3:0]            mcause_code_o;
   logic [XLEN-1:0]       exc_pc_o;
   logic                  irq_wait_o;
   logic [CNT_W-1:0]      perf_stall_cnt_o;
   logic [CNT_W-1:0]      perf_flush_cnt_o;
   logic [15:0]           perf_drain_max_o;

   modport master (
      output stall_cause_i, flush_cause_i, instr_valid_i, irq_pending_i, irq_global_en_i,
             trap_valid_i, trap_is_mret_i, trap_code_i, trap_pc_i, fetch_pc_i, branch_taken_i,
      input  stall_o, flush_o, new_pc_en_o, pc_sel_o, is_trap_o, mret_o, mcause_irq_o,
             mcause_code_o, exc_pc_o, irq_wait_o, perf_stall_cnt_o, perf_flush_cnt_o,
             perf_drain_max_o
   );

   modport slave (
      input  stall_cause_i, flush_cause_i, instr_valid_i, irq_pending_i, irq_global_en_i,
             trap_valid_i, trap_is_mret_i, trap_code_i, trap_pc_i, fetch_pc_i, branch_taken_i,
      output stall_o, flush_o, new_pc_en_o, pc_sel_o, is_trap_o, mret_o, mcause_irq_o,
             mcause_code_o, exc_pc_o, irq_wait_o, perf_stall_cnt_o, perf_flush_cnt_o,
             perf_drain_max_o
   );
endinterface

// File: rtl/pipe_hazard_ctrl_irq_prio_enc.sv
// Fixed-priority interrupt encoder: lowest set request index wins and is mapped
// through a packed table of 4-bit cause codes.
module irq_prio_enc
   import pipe_hazard_ctrl_pkg::*;
#(
   parameter int                   NUM_IRQ   = 3,
   parameter logic [NUM_IRQ*4-1:0] IRQ_CODES = {IRQ_CODE_MEI, IRQ_CODE_MTI, IRQ_CODE_MSI}
) (
   input  logic [NUM_IRQ-1:0] req_i,
   output logic               valid_o,
   output logic [3:0]         code_o
);

   // Scan from lowest priority upward so the lowest set index overwrites last.
   always_comb begin
      valid_o = |req_i;
      code_o  = 4'd0;
      for (int i = NUM_IRQ - 1; i >= 0; i--) begin
         if (req_i[i]) code_o = IRQ_CODES[4*i +: 4];
      end
   end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: per-register stall/flush generation, interrupt
// drain FSM and fetch steering for traps, MRET, interrupts and branches.
// Optional performance counters are built when HAZARD_PERF_CNT_EN is defined.
module pipe_hazard_ctrl
   import pipe_hazard_ctrl_pkg::*;
#(
   parameter int                   NUM_STAGES   = 4,
   parameter int                   NUM_IRQ      = 3,
   parameter logic [NUM_IRQ*4-1:0] IRQ_CODES    = {IRQ_CODE_MEI, IRQ_CODE_MTI, IRQ_CODE_MSI},
   parameter int                   TRAP_STAGE   = 2,
   parameter int                   BRANCH_STAGE = 1,
   parameter int                   XLEN         = 32,
   parameter int                   CNT_W        = 32
) (
   input logic               clk_i,
   input logic               rst_i,
   pipe_hazard_ctrl_if.slave bus
);

   localparam logic [0:0] ST_IDLE  = IDLE;
   localparam logic [0:0] ST_DRAIN = DRAIN;

   logic [0:0]            state_q, state_d;
   logic                  trap, irq_req, draining, pipe_busy, take_irq;
   logic                  irq_valid;
   logic [3:0]            irq_code;
   logic [NUM_STAGES-1:0] redir_flush, eff_cause, stall_c, flush_c;
   logic                  hold;
   logic                  new_pc_en_c, is_trap_c, mret_c;
   pc_sel_t               pc_sel_c;
   mcause_t               mcause_c;
   logic [XLEN-1:0]       exc_pc_c;

   irq_prio_enc #(
      .NUM_IRQ   (NUM_IRQ),
      .IRQ_CODES (IRQ_CODES)
   ) u_irq_prio_enc (
      .req_i   (bus.irq_pending_i),
      .valid_o (irq_valid),
      .code_o  (irq_code)
   );

   // Interrupt qualification and drain FSM next-state.
   always_comb begin
      trap      = bus.trap_valid_i;
      irq_req   = bus.irq_global_en_i & (|bus.irq_pending_i);
      draining  = (state_q == ST_DRAIN);
      // Register 0 is about to be replaced by the handler fetch, so only older ones matter.
      pipe_busy = |(bus.instr_valid_i & ~{{(NUM_STAGES-1){1'b0}}, 1'b1});
      take_irq  = draining & ~trap & irq_req & irq_valid & ~pipe_busy;
      state_d   = state_q;
      if (!draining) begin
         // A trap in the same cycle wins; the interrupt is re-evaluated afterwards.
         if (irq_req && !trap) state_d = ST_DRAIN;
      end else begin
         if (trap || !irq_req || take_irq) state_d = ST_IDLE;
      end
   end

   // Stall chain (older holds force younger holds) and bubble insertion.
   always_comb begin
      redir_flush = '0;
      eff_cause   = '0;
      stall_c     = '0;
      flush_c     = '0;
      hold        = 1'b0;
      for (int k = NUM_STAGES - 1; k >= 0; k--) begin
         redir_flush[k] = bus.flush_cause_i[k];
         if (k >= 1 && k <= TRAP_STAGE)   redir_flush[k] = redir_flush[k] | trap;
         if (k >= 1 && k <= BRANCH_STAGE) redir_flush[k] = redir_flush[k] | bus.branch_taken_i;
         eff_cause[k] = bus.stall_cause_i[k] & ~redir_flush[k];
         if (k == 0) eff_cause[k] = eff_cause[k] | draining;
         hold       = hold | eff_cause[k];
         stall_c[k] = hold;
      end
      flush_c[0] = bus.flush_cause_i[0];
      for (int k = 1; k < NUM_STAGES; k++) begin
         flush_c[k] = redir_flush[k] | (stall_c[k-1] & ~stall_c[k]);
      end
   end

   // Fetch steering with priority trap > interrupt > branch.
   always_comb begin
      new_pc_en_c = 1'b0;
      pc_sel_c    = PC_JUMP;
      is_trap_c   = 1'b0;
      mret_c      = 1'b0;
      mcause_c    = '{irq: 1'b0, code: bus.trap_code_i};
      exc_pc_c    = bus.trap_pc_i;
      if (trap) begin
         new_pc_en_c = 1'b1;
         if (bus.trap_is_mret_i) begin
            pc_sel_c = PC_MEPC;
            mret_c   = 1'b1;
         end else begin
            pc_sel_c  = PC_TRAP;
            is_trap_c = 1'b1;
         end
      end else if (take_irq) begin
         new_pc_en_c = 1'b1;
         pc_sel_c    = PC_TRAP;
         is_trap_c   = 1'b1;
         mcause_c    = '{irq: 1'b1, code: irq_code};
         exc_pc_c    = bus.fetch_pc_i;
      end else if (bus.branch_taken_i) begin
         new_pc_en_c = 1'b1;
      end
   end

   // Drain FSM state register.
   always_ff @(posedge clk_i) begin
      if (rst_i) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   // Outputs are forced quiet while reset is held.
   assign bus.stall_o       = rst_i ? '0 : stall_c;
   assign bus.flush_o       = rst_i ? '0 : flush_c;
   assign bus.new_pc_en_o   = ~rst_i & new_pc_en_c;
   assign bus.pc_sel_o      = rst_i ? PC_JUMP : pc_sel_c;
   assign bus.is_trap_o     = ~rst_i & is_trap_c;
   assign bus.mret_o        = ~rst_i & mret_c;
   assign bus.mcause_irq_o  = ~rst_i & mcause_c.irq;
   assign bus.mcause_code_o = rst_i ? 4'd0 : mcause_c.code;
   assign bus.exc_pc_o      = rst_i ? '0 : exc_pc_c;
   assign bus.irq_wait_o    = ~rst_i & draining;

`ifdef HAZARD_PERF_CNT_EN
   logic [CNT_W-1:0] perf_stall_q, perf_stall_d;
   logic [CNT_W-1:0] perf_flush_q, perf_flush_d;
   logic [15:0]      drain_cnt_q, drain_cnt_d;
   logic [15:0]      drain_max_q, drain_max_d;
   logic [15:0]      drain_inc;

   // Saturating event counters and longest-drain tracker (exit cycle included).
   always_comb begin
      perf_stall_d = perf_stall_q;
      perf_flush_d = perf_flush_q;
      drain_cnt_d  = 16'd0;
      drain_max_d  = drain_max_q;
      drain_inc    = (drain_cnt_q == 16'hFFFF) ? drain_cnt_q : drain_cnt_q + 16'd1;
      if (stall_c[0] && perf_stall_q != '1) perf_stall_d = perf_stall_q + CNT_W'(1);
      if (new_pc_en_c && perf_flush_q != '1) perf_flush_d = perf_flush_q + CNT_W'(1);
      if (draining) begin
         if (state_d == ST_IDLE) begin
            if (drain_inc > drain_max_q) drain_max_d = drain_inc;
         end else begin
            drain_cnt_d = drain_inc;
         end
      end
   end

   // Counter registers, cleared by reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         perf_stall_q <= '0;
         perf_flush_q <= '0;
         drain_cnt_q  <= '0;
         drain_max_q  <= '0;
      end else begin
         perf_stall_q <= perf_stall_d;
         perf_flush_q <= perf_flush_d;
         drain_cnt_q  <= drain_cnt_d;
         drain_max_q  <= drain_max_d;
      end
   end

   assign bus.perf_stall_cnt_o = rst_i ? '0 : perf_stall_q;
   assign bus.perf_flush_cnt_o = rst_i ? '0 : perf_flush_q;
   assign bus.perf_drain_max_o = rst_i ? '0 : drain_max_q;
`else
   assign bus.perf_stall_cnt_o = {CNT_W{1'b0}};
   assign bus.perf_flush_cnt_o = {CNT_W{1'b0}};
   assign bus.perf_drain_max_o = 16'd0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: directed per-cycle vectors push expected
// outputs; a negedge monitor pops and compares.
module tb_pipe_hazard_ctrl;
   import pipe_hazard_ctrl_pkg::*;

`ifdef HAZARD_PERF_CNT_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   pipe_hazard_ctrl_if bus_if ();

   pipe_hazard_ctrl dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus_if)
   );

   typedef struct {
      string       nm;
      logic [3:0]  st;
      logic [3:0]  fl;
      logic        npc;
      logic [1:0]  sel;
      logic        trp;
      logic        mr;
      logic        mi;
      logic [3:0]  mc;
      logic [31:0] epc;
      logic        wt;
      bit          cp;
      logic [31:0] ps;
      logic [31:0] pf;
      logic [15:0] pd;
   } exp_t;

   exp_t        sb[$];
   int          tests = 0;
   int          fails = 0;
   bit          perf_pend = 1'b0;
   logic [31:0] perf_s, perf_f;
   logic [15:0] perf_d;

   task automatic cmp(input string nm, input string f, input logic [31:0] a, input logic [31:0] e);
      tests++;
      if (a !== e) begin
         fails++;
         $display("FAIL %s.%s actual=%0h required=%0h", nm, f, a, e);
      end
   endtask

   // Monitor: compare the DUT against the oldest expectation each negedge.
   initial begin
      forever begin
         @(negedge clk);
         if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            cmp(e.nm, "stall",   32'(bus_if.stall_o),       32'(e.st));
            cmp(e.nm, "flush",   32'(bus_if.flush_o),       32'(e.fl));
            cmp(e.nm, "new_pc",  32'(bus_if.new_pc_en_o),   32'(e.npc));
            cmp(e.nm, "pc_sel",  32'(bus_if.pc_sel_o),      32'(e.sel));
            cmp(e.nm, "is_trap", 32'(bus_if.is_trap_o),     32'(e.trp));
            cmp(e.nm, "mret",    32'(bus_if.mret_o),        32'(e.mr));
            cmp(e.nm, "mc_irq",  32'(bus_if.mcause_irq_o),  32'(e.mi));
            cmp(e.nm, "mc_code", 32'(bus_if.mcause_code_o), 32'(e.mc));
            cmp(e.nm, "exc_pc",  bus_if.exc_pc_o,           e.epc);
            cmp(e.nm, "wait",    32'(bus_if.irq_wait_o),    32'(e.wt));
            if (e.cp) begin
               cmp(e.nm, "perf_stall", bus_if.perf_stall_cnt_o, e.ps);
               cmp(e.nm, "perf_flush", bus_if.perf_flush_cnt_o, e.pf);
               cmp(e.nm, "perf_drain", 32'(bus_if.perf_drain_max_o), 32'(e.pd));
            end
         end
      end
   end

   task automatic set_in(input logic [3:0] st, input logic [3:0] fl, input logic [3:0] vld,
                         input logic [2:0] pend, input logic en, input logic tv, input logic mret,
                         input logic [3:0] code, input logic [31:0] tpc, input logic br);
      bus_if.stall_cause_i   = st;
      bus_if.flush_cause_i   = fl;
      bus_if.instr_valid_i   = vld;
      bus_if.irq_pending_i   = pend;
      bus_if.irq_global_en_i = en;
      bus_if.trap_valid_i    = tv;
      bus_if.trap_is_mret_i  = mret;
      bus_if.trap_code_i     = code;
      bus_if.trap_pc_i       = tpc;
      bus_if.fetch_pc_i      = 32'h200;
      bus_if.branch_taken_i  = br;
   endtask

   task automatic expect_perf(input logic [31:0] s, input logic [31:0] f, input logic [15:0] d);
      perf_pend = 1'b1;
      perf_s    = PERF ? s : 32'd0;
      perf_f    = PERF ? f : 32'd0;
      perf_d    = PERF ? d : 16'd0;
   endtask

   // Push the expectation for the inputs just applied, then advance one cycle.
   task automatic expect_cyc(input string nm, input logic [3:0] st, input logic [3:0] fl,
                             input logic npc, input logic [1:0] sel, input logic trp,
                             input logic mr, input logic mi, input logic [3:0] mc,
                             input logic [31:0] epc, input logic wt);
      exp_t e;
      e.nm = nm; e.st = st; e.fl = fl; e.npc = npc; e.sel = sel; e.trp = trp;
      e.mr = mr; e.mi = mi; e.mc = mc; e.epc = epc; e.wt = wt;
      e.cp = perf_pend; e.ps = perf_s; e.pf = perf_f; e.pd = perf_d;
      perf_pend = 1'b0;
      sb.push_back(e);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      set_in(4'b0100, 4'b0000, 4'b0000, 3'b000, 1'b0, 1'b1, 1'b0, 4'd2, 32'h100, 1'b0);
      @(posedge clk);
      #1;
      // Reset held: everything quiet even with active causes.
      rst = 1'b1;
      expect_perf(0, 0, 0);
      expect_cyc("reset",      4'b0000, 4'b0000, 0, 2'd0, 0, 0, 0, 4'd0, 32'h0,   0);
      rst = 1'b0;
      set_in(4'b0100, 4'b0000, 4'b0000, 3'b000, 1'b0, 1'b0, 1'b0, 4'd0, 32'h0, 1'b0);
      expect_cyc("stall_0100", 4'b0111, 4'b1000, 0, 2'd0, 0, 0, 0, 4'd0, 32'h0,   0);
      set_in(4'b1111, 4'b0000, 4'b0000, 3'b000, 1'b0, 1'b0, 1'b0, 4'd0, 32'h0, 1'b0);
      expect_cyc("stall_all",  4'b1111, 4'b0000, 0, 2'd0, 0, 0, 0, 4'd0, 32'h0,   0);
      set_in(4'b0000, 4'b0000, 4'b0000, 3'b000, 1'b0, 1'b1, 1'b0, 4'd2, 32'h100, 1'b0);
      expect_cyc("trap",       4'b0000, 4'b0110, 1, 2'd1, 1, 0, 0, 4'd2, 32'h100, 0);
      set_in(4'b0000, 4'b0000, 4'b0000, 3'b000, 1'b0, 1'b1, 1'b1, 4'd2, 32'h100, 1'b1);
      expect_cyc("mret_br",    4'b0000, 4'b0110, 1, 2'd2, 0, 1, 0, 4'd2, 32'h100, 0);
      set_in(4'b0000, 4'b0000, 4'b0000, 3'b000, 1'b0, 1'b0, 1'b0, 4'd0, 32'h0, 1'b1);
      expect_cyc("branch",     4'b0000, 4'b0010, 1, 2'd0, 0, 0, 0, 4'd0, 32'h0,   0);
      set_in(4'b0001, 4'b0000, 4'b0000, 3'b000, 1'b0, 1'b0, 1'b0, 4'd0, 32'h0, 1'b1);
      expect_cyc("br_stall0",  4'b0001, 4'b0010, 1, 2'd0, 0, 0, 0, 4'd0, 32'h0,   0);
      set_in(4'b0010, 4'b0010, 4'b0000, 3'b000, 1'b0, 1'b0, 1'b0, 4'd0, 32'h0, 1'b0);
      expect_cyc("ext_flush",  4'b0000, 4'b0010, 0, 2'd0, 0, 0, 0, 4'd0, 32'h0,   0);
      // Interrupt drain: three busy cycles, then empty -> take with code 7.
      set_in(4'b0000, 4'b0000, 4'b1110, 3'b110, 1'b1, 1'b0, 1'b0, 4'd0, 32'h0, 1'b0);
      expect_cyc("irq_entry",  4'b0000, 4'b0000, 0, 2'd0, 0, 0, 0, 4'd0, 32'h0,   0);
      expect_cyc("drain1",     4'b0001, 4'b0010, 0, 2'd0, 0, 0, 0, 4'd0, 32'h0,   1);
      expect_cyc("drain2",     4'b0001, 4'b0010, 0, 2'd0, 0, 0, 0, 4'd0, 32'h0,   1);
      expect_cyc("drain3",     4'b0001, 4'b0010, 0, 2'd0, 0, 0, 0, 4'd0, 32'h0,   1);
      bus_if.instr_valid_i = 4'b0001;
      expect_cyc("take7",      4'b0001, 4'b0010, 1, 2'd1, 1, 0, 1, 4'd7, 32'h200, 1);
      set_in(4'b0000, 4'b0000, 4'b0000, 3'b000, 1'b1, 1'b0, 1'b0, 4'd0, 32'h0, 1'b0);
      expect_perf(7, 5, 4);
      expect_cyc("post_take",  4'b0000, 4'b0000, 0, 2'd0, 0, 0, 0, 4'd0, 32'h0,   0);
      // Higher-priority line arrives mid-drain and wins.
      set_in(4'b0000, 4'b0000, 4'b1110, 3'b100, 1'b1, 1'b0, 1'b0, 4'd0, 32'h0, 1'b0);
      expect_cyc("irq2_entry", 4'b0000, 4'b0000, 0, 2'd0, 0, 0, 0, 4'd0, 32'h0,   0);
      bus_if.irq_pending_i = 3'b101;
      expect_cyc("irq2_drain", 4'b0001, 4'b0010, 0, 2'd0, 0, 0, 0, 4'd0, 32'h0,   1);
      bus_if.instr_valid_i = 4'b0000;
      expect_cyc("take3",      4'b0001, 4'b0010, 1, 2'd1, 1, 0, 1, 4'd3, 32'h200, 1);
      bus_if.irq_pending_i = 3'b000;
      expect_cyc("post_take3", 4'b0000, 4'b0000, 0, 2'd0, 0, 0, 0, 4'd0, 32'h0,   0);
      // Enable drops before the pipeline empties: abandon without redirect.
      set_in(4'b0000, 4'b0000, 4'b1110, 3'b010, 1'b1, 1'b0, 1'b0, 4'd0, 32'h0, 1'b0);
      expect_cyc("irq3_entry", 4'b0000, 4'b0000, 0, 2'd0, 0, 0, 0, 4'd0, 32'h0,   0);
      expect_cyc("irq3_drain", 4'b0001, 4'b0010, 0, 2'd0, 0, 0, 0, 4'd0, 32'h0,   1);
      bus_if.irq_global_en_i = 1'b0;
      expect_cyc("en_drop",    4'b0001, 4'b0010, 0, 2'd0, 0, 0, 0, 4'd0, 32'h0,   1);
      expect_cyc("abandoned",  4'b0000, 4'b0000, 0, 2'd0, 0, 0, 0, 4'd0, 32'h0,   0);
      // Trap coincides with drain entry: trap served, FSM stays idle.
      set_in(4'b0000, 4'b0000, 4'b1110, 3'b010, 1'b1, 1'b1, 1'b0, 4'd5, 32'h300, 1'b0);
      expect_cyc("trap_vs_irq",4'b0000, 4'b0110, 1, 2'd1, 1, 0, 0, 4'd5, 32'h300, 0);
      bus_if.trap_valid_i = 1'b0;
      bus_if.trap_code_i  = 4'd0;
      bus_if.trap_pc_i    = 32'h0;
      expect_cyc("stayed_idle",4'b0000, 4'b0000, 0, 2'd0, 0, 0, 0, 4'd0, 32'h0,   0);
      expect_cyc("irq4_drain", 4'b0001, 4'b0010, 0, 2'd0, 0, 0, 0, 4'd0, 32'h0,   1);
      // Reset mid-drain.
      rst = 1'b1;
      expect_cyc("rst_drain",  4'b0000, 4'b0000, 0, 2'd0, 0, 0, 0, 4'd0, 32'h0,   0);
      rst = 1'b0;
      expect_perf(0, 0, 0);
      expect_cyc("after_rst",  4'b0000, 4'b0000, 0, 2'd0, 0, 0, 0, 4'd0, 32'h0,   0);
      for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
      if (sb.size() > 0) begin
         fails++;
         tests++;
         $display("FAIL drain_scoreboard actual=%0d pending required=0", sb.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Parametrised pipeline control unit for the in-order core.
- Generalises stall/flush generation to NUM_STAGES pipeline registers with per-register stall/flush causes.
- Arbitrates NUM_IRQ prioritised interrupt lines through a drain state machine.
- Steers fetch on traps, MRET, interrupts and taken branches. Sits beside the datapath; drives every pipeline register's hold/bubble controls and the PC mux.

Parameters:
- NUM_STAGES, 4: number of pipeline registers. Index 0 is youngest (IF/ID); NUM_STAGES-1 is oldest (MEM/WB).
- NUM_IRQ, 3: interrupt request lines. Index 0 has highest priority.
- IRQ_CODES, {4'd11,4'd7,4'd3}: packed NUM_IRQ*4 mcause codes. Entry i sits at bits [4i+3:4i].
- TRAP_STAGE, 2: index of the register whose instruction reports traps/MRET.
- BRANCH_STAGE, 1: index of the register whose instruction resolves branches.
- XLEN, 32: PC width.
- CNT_W, 32: perf counter width.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- stall_cause_i  in  NUM_STAGES  local hold request per register
- flush_cause_i  in  NUM_STAGES  external bubble request per register
- instr_valid_i  in  NUM_STAGES  valid bit held in each register
- irq_pending_i  in  NUM_IRQ  pending and enabled interrupts
- irq_global_en_i  in  1  mstatus.MIE OR (priv==U)
- trap_valid_i  in  1  instruction at TRAP_STAGE raised a trap
- trap_is_mret_i  in  1  the trap is an MRET
- trap_code_i  in  4  exception code
- trap_pc_i  in  XLEN  PC of the trapping instruction
- fetch_pc_i  in  XLEN  current fetch PC
- branch_taken_i  in  1  branch at BRANCH_STAGE redirects
- stall_o  out  NUM_STAGES  hold each register
- flush_o  out  NUM_STAGES  load a bubble into each register
- new_pc_en_o  out  1  redirect fetch
- pc_sel_o  out  2  pc_sel_t
- is_trap_o  out  1  write mepc/mcause
- mret_o  out  1  MRET side effects
- mcause_irq_o  out  1  mcause interrupt bit
- mcause_code_o  out  4  mcause code
- exc_pc_o  out  XLEN  value to save into mepc
- irq_wait_o  out  1  FSM is in DRAIN
- perf_stall_cnt_o  out  CNT_W  cycles with stall_o[0] high
- perf_flush_cnt_o  out  CNT_W  redirect events
- perf_drain_max_o  out  16  longest drain seen

Behaviour:
- Reset (rst_i high at a clk_i edge): state=IDLE; counters cleared. While in reset, every output is 0 and pc_sel_o=PC_JUMP.
- Traps:
  - trap = trap_valid_i.
  - Redirect cause kind is trap, irq or branch, with priority trap > take_irq > branch_taken_i.
- Effective stall cause for register k: stall_cause_i[k] & ~flush_k, where flush_k is the flush from external, trap or branch for that k.
  - Register 0 also gets the cause state==DRAIN.
  - stall_o[k] = eff_cause[k] | stall_o[k+1]. The oldest register has no k+1 term.
- Flush, where k>=1 for the bubble term:
  - flush_o[k] = flush_cause_i[k] | (trap & k<=TRAP_STAGE & k>=1) | (branch_taken_i & k<=BRANCH_STAGE & k>=1) | (stall_o[k-1] & ~stall_o[k]).
  - flush_o[0] = flush_cause_i[0].
- Stall and flush outputs are combinational, same cycle as their inputs.
- IRQ FSM, registered state:
  - IDLE -> DRAIN when irq_global_en_i & |irq_pending_i.
  - In DRAIN:
    - If trap, or NOT(irq_global_en_i & |irq_pending_i): go to IDLE, no take.
    - Otherwise, if instr_valid_i[1..NUM_STAGES-1] are all 0: take_irq pulses for 1 cycle, then IDLE.
    - Otherwise stay in DRAIN.
- IRQ code: lowest set index of irq_pending_i, mapped through IRQ_CODES. It is re-evaluated every cycle, so a higher-priority line arriving mid-drain wins.
- Steering:
  - trap & mret: new_pc_en_o=1, pc_sel_o=PC_MEPC, mret_o=1.
  - trap & not mret: new_pc_en_o=1, pc_sel_o=PC_TRAP, is_trap_o=1, mcause={0, trap_code_i}, exc_pc_o=trap_pc_i.
  - take_irq: new_pc_en_o=1, pc_sel_o=PC_TRAP, is_trap_o=1, mcause={1, code}, exc_pc_o=fetch_pc_i.
  - branch_taken_i: new_pc_en_o=1, pc_sel_o=PC_JUMP.
  - Idle defaults: pc_sel_o=PC_JUMP, exc_pc_o=trap_pc_i, mcause={0, trap_code_i}.
- Boundaries:
  - trap and entry into DRAIN in the same cycle: trap is served; FSM stays IDLE.
  - Reset asserted mid-DRAIN: IDLE next cycle; no take.
  - All stall causes high: every register holds and no flush is asserted.

Optional Feature:
- Macro HAZARD_PERF_CNT_EN.
  - Defined:
    - perf_stall_cnt_o increments each cycle stall_o[0]=1.
    - perf_flush_cnt_o increments each cycle new_pc_en_o=1.
    - Both counters saturate at all-ones.
    - A 16-bit drain counter counts DRAIN cycles. On DRAIN exit, perf_drain_max_o = max(perf_drain_max_o, count).
  - Undefined: all perf outputs are constant 0 and no counter flops are built.

Decomposition:
- Shared package gets:
  - pc_sel_t {PC_JUMP=0, PC_TRAP=1, PC_MEPC=2};
  - ctrl_state_e {IDLE, DRAIN};
  - the mcause struct {irq, code[3:0]};
  - default IRQ code constants 3/7/11.
- One natural sub-module, irq_prio_enc: parametrised fixed-priority encoder that produces valid plus the 4-bit code.

Test Plan:
- stall_cause_i=4'b0100, no flushes -> stall_o=4'b0111, flush_o=4'b1000.
- trap_valid_i=1, trap_code_i=2, trap_pc_i=0x100 -> flush_o=4'b0110, pc_sel_o=PC_TRAP, mcause={0,2}, exc_pc_o=0x100, all in the same cycle.
- irq_pending_i=3'b110, irq_global_en_i=1, instr_valid_i=4'b1110 held 3 cycles then 4'b0001 -> one cycle of take_irq with mcause={1,7}, exc_pc_o=fetch_pc_i, stall_o[0] high during DRAIN. With HAZARD_PERF_CNT_EN, perf_drain_max_o=4.
- In DRAIN, irq_global_en_i drops before the pipeline is empty -> IDLE, no redirect.
- trap_is_mret_i=1 and branch_taken_i=1 together -> pc_sel_o=PC_MEPC, mret_o=1, flush_o=4'b0110.
- rst_i asserted mid-DRAIN -> irq_wait_o=0 next cycle, counters 0.
